// File: rtl/dac_spi_writer_if.sv
// Upstream handshake and DAC pin bundle for dac_spi_writer.
// The preprocessor side uses the master modport, the serializer the slave modport.
interface dac_spi_writer_if #(
    parameter int W_DATA = 16
);
    logic [W_DATA-1:0] data_in;
    logic              data_valid_in;
    logic [2:0]        channel_in;
    logic              dac_sclk_out;
    logic              dac_sync_n_out;
    logic              dac_din_out;
    logic              busy_out;
    logic              done_out;
    logic              overrun_out;

    modport master (
        output data_in,
        output data_valid_in,
        output channel_in,
        input  dac_sclk_out,
        input  dac_sync_n_out,
        input  dac_din_out,
        input  busy_out,
        input  done_out,
        input  overrun_out
    );

    modport slave (
        input  data_in,
        input  data_valid_in,
        input  channel_in,
        output dac_sclk_out,
        output dac_sync_n_out,
        output dac_din_out,
        output busy_out,
        output done_out,
        output overrun_out
    );
endinterface

// File: rtl/dac_spi_writer.sv
// Serializes signed preprocessor words into 24-bit write-and-update frames for a
// DAC8568-style SPI DAC. Data is converted to offset binary, one word can be held
// pending while a frame or the inter-frame gap is in progress.
// W_DATA must be 16: the frame data field is fixed at 16 bits.
module dac_spi_writer #(
    parameter int         W_DATA     = 16,
    parameter int         CLK_DIV    = 2,
    parameter int         GAP_CYCLES = 4,
    parameter logic [3:0] CMD        = 4'b0011
) (
    input  logic             clk_in,
    input  logic             reset_in,
    dac_spi_writer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam logic [8:0] PH_LAST  = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0] SCLK_HI  = 9'(CLK_DIV);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    // Frame: command, reserved zero, channel, offset-binary data.
    function automatic logic [23:0] make_frame(input logic [2:0] ch, input logic [15:0] d);
        return {CMD, 1'b0, ch, ~d[15], d[14:0]};
    endfunction

    state_t      state_reg, state_next;
    logic [4:0]  bit_reg, bit_next;
    logic [8:0]  phase_reg, phase_next;
    logic [7:0]  gap_reg, gap_next;
    logic [23:0] frame_reg, frame_next;
    logic        pend_full_reg, pend_full_next;
    logic [23:0] pend_frame_reg, pend_frame_next;

    logic        sclk_reg, sclk_next;
    logic        sync_n_reg, sync_n_next;
    logic        din_reg, din_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        overrun_reg, overrun_next;

    logic [W_DATA-1:0] data_w;
    logic [23:0]       in_frame;
    logic              load_pend;
    logic              take_direct;
    logic              overrun_evt;

    assign data_w   = bus.data_in;
    assign in_frame = make_frame(bus.channel_in, data_w[15:0]);

    // State, counters, frame/pending storage and registered outputs.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_reg      <= IDLE;
            bit_reg        <= '0;
            phase_reg      <= '0;
            gap_reg        <= '0;
            frame_reg      <= '0;
            pend_full_reg  <= 1'b0;
            pend_frame_reg <= '0;
            sclk_reg       <= 1'b0;
            sync_n_reg     <= 1'b1;
            din_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_reg        <= bit_next;
            phase_reg      <= phase_next;
            gap_reg        <= gap_next;
            frame_reg      <= frame_next;
            pend_full_reg  <= pend_full_next;
            pend_frame_reg <= pend_frame_next;
            sclk_reg       <= sclk_next;
            sync_n_reg     <= sync_n_next;
            din_reg        <= din_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            overrun_reg    <= overrun_next;
        end
    end

    // Next state, bit/phase/gap counters and the one-entry pending slot.
    always_comb begin
        state_next      = state_reg;
        bit_next        = bit_reg;
        phase_next      = phase_reg;
        gap_next        = gap_reg;
        frame_next      = frame_reg;
        pend_full_next  = pend_full_reg;
        pend_frame_next = pend_frame_reg;
        load_pend       = 1'b0;
        take_direct     = 1'b0;
        overrun_evt     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.data_valid_in) begin
                    frame_next = in_frame;
                    state_next = SHIFT;
                    bit_next   = 5'd23;
                    phase_next = '0;
                end
            end
            SHIFT: begin
                if (phase_reg == PH_LAST) begin
                    phase_next = '0;
                    if (bit_reg == 5'd0) begin
                        state_next = GAP;
                        gap_next   = '0;
                    end else begin
                        bit_next = bit_reg - 5'd1;
                    end
                end else begin
                    phase_next = phase_reg + 9'd1;
                end
            end
            GAP: begin
                if (gap_reg == GAP_LAST) begin
                    if (pend_full_reg) begin
                        // Older pending word goes out first; a same-cycle strobe
                        // refills the slot below.
                        frame_next = pend_frame_reg;
                        load_pend  = 1'b1;
                        state_next = SHIFT;
                        bit_next   = 5'd23;
                        phase_next = '0;
                    end else if (bus.data_valid_in) begin
                        // Strobe on the last gap cycle with nothing pending is sent
                        // straight away rather than parking in the slot.
                        frame_next  = in_frame;
                        take_direct = 1'b1;
                        state_next  = SHIFT;
                        bit_next    = 5'd23;
                        phase_next  = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_next = gap_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (load_pend) begin
            pend_full_next = 1'b0;
        end
        if (bus.data_valid_in && (state_reg != IDLE) && !take_direct) begin
            pend_frame_next = in_frame;
            pend_full_next  = 1'b1;
            overrun_evt     = pend_full_reg && !load_pend;
        end
    end

    // Output values derived from the upcoming state so every pin is a flop.
    always_comb begin
        sync_n_next  = 1'b1;
        sclk_next    = 1'b0;
        din_next     = 1'b0;
        busy_next    = (state_next != IDLE);
        done_next    = (state_reg == SHIFT) && (state_next == GAP);
        overrun_next = overrun_evt;
        if (state_next == SHIFT) begin
            sync_n_next = 1'b0;
            sclk_next   = (phase_next < SCLK_HI);
            din_next    = frame_next[bit_next];
        end
    end

    assign bus.dac_sclk_out   = sclk_reg;
    assign bus.dac_sync_n_out = sync_n_reg;
    assign bus.dac_din_out    = din_reg;
    assign bus.busy_out       = busy_reg;
    assign bus.done_out       = done_reg;
    assign bus.overrun_out    = overrun_reg;
endmodule
